// File: rtl/image_pkg.sv
// image_pkg: shared geometry and FSM encoding for the DDR-to-image read path.
// Holds the band geometry (LINE_W x FRAME_H pixels of PIX_W bits carried in
// DDR_W-bit words), derived counter widths and the band sequencer state enum.
package image_pkg;

    localparam int LINE_W  = 1280;
    localparam int FRAME_H = 16;
    localparam int PIX_W   = 24;
    localparam int DDR_W   = 512;

    // DDR words that carry exactly one band of pixels
    localparam int WORDS_PER_BAND = LINE_W * FRAME_H * PIX_W / DDR_W;

    // Fill counter must be able to represent a completely full residue (2*DDR_W)
    localparam int FILL_W     = $clog2(2 * DDR_W + 1);
    localparam int WCNT_W     = $clog2(WORDS_PER_BAND + 1);
    localparam int COL_W      = $clog2(LINE_W);
    localparam int LINE_CNT_W = $clog2(FRAME_H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pix_gearbox.sv
// pix_gearbox: DDR_W -> PIX_W width converter.
// A 2*DDR_W-bit residue register holds unconsumed bits MSB-aligned; `fill`
// counts the valid bits from the top. The output pixel is always the top PIX_W
// bits. A pop shifts the residue left by PIX_W; a push ORs the incoming word in
// directly below the bits that survive the pop, so push and pop can share a
// cycle. Bits below the fill level are kept at zero, which makes the OR-merge safe.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   accept_en           sequencer permits word intake (RUN with words remaining)
//   emit_en             sequencer permits pixel output (RUN or DRAIN)
//   in_valid/in_ready   word handshake, in_data MSB = earliest pixel bit
//   out_valid/out_ready pixel handshake, out_pix = top PIX_W residue bits
module pix_gearbox
    import image_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             accept_en,
    input  logic             emit_en,
    input  logic             in_valid,
    input  logic [DDR_W-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix
);

    localparam logic [FILL_W-1:0] PIX_F = FILL_W'(PIX_W);
    localparam logic [FILL_W-1:0] DDR_F = FILL_W'(DDR_W);

    logic [2*DDR_W-1:0] res_r;
    logic [2*DDR_W-1:0] res_pop_s;
    logic [2*DDR_W-1:0] res_nxt_s;
    logic [FILL_W-1:0]  fill_r;
    logic [FILL_W-1:0]  fill_pop_s;
    logic [FILL_W-1:0]  fill_nxt_s;
    logic               push_s;
    logic               pop_s;

    // Both flags decode registered state only, so they are glitch-free per cycle
    assign in_ready  = accept_en && (fill_r <= DDR_F);
    assign out_valid = emit_en && (fill_r >= PIX_F);
    assign out_pix   = res_r[2*DDR_W-1 -: PIX_W];

    // Next residue/fill: pop first, then merge the new word below surviving bits
    always_comb begin
        push_s     = in_valid && in_ready;
        pop_s      = out_valid && out_ready;
        res_pop_s  = res_r;
        fill_pop_s = fill_r;
        res_nxt_s  = res_r;
        fill_nxt_s = fill_r;
        if (pop_s) begin
            res_pop_s  = res_r << PIX_W;
            fill_pop_s = fill_r - PIX_F;
        end else begin
            res_pop_s  = res_r;
            fill_pop_s = fill_r;
        end
        if (push_s) begin
            res_nxt_s  = res_pop_s | ({in_data, {DDR_W{1'b0}}} >> fill_pop_s);
            fill_nxt_s = fill_pop_s + DDR_F;
        end else begin
            res_nxt_s  = res_pop_s;
            fill_nxt_s = fill_pop_s;
        end
    end

    // Residue and fill state
    always_ff @(posedge clk) begin
        if (rst) begin
            res_r  <= '0;
            fill_r <= '0;
        end else begin
            res_r  <= res_nxt_s;
            fill_r <= fill_nxt_s;
        end
    end

endmodule

// File: rtl/ddr2image.sv
// ddr2image: unpacks 512-bit DDR read words into a 24-bit RGB pixel stream and
// tags start-of-band / start-of-line / end-of-line for one LINE_W x FRAME_H band
// per `start` pulse.
// Ports:
//   clk_266, rst_266             clock, synchronous active-high reset
//   start, busy, done            band control / status
//   in_valid, in_ready, in_data  DDR word input (MSB = earliest pixel)
//   out_valid, out_ready,
//   out_pix, out_sof/sol/eol     pixel output and boundary tags
//   stall_cnt                    output-starvation cycle counter
// Optional feature: define DDR2IMAGE_STALL_CNT_EN to build the starvation
// counter; otherwise stall_cnt is tied to zero.
module ddr2image
    import image_pkg::*;
(
    input  logic             clk_266,
    input  logic             rst_266,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DDR_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_sof,
    output logic             out_sol,
    output logic             out_eol,
    output logic [31:0]      stall_cnt
);

    if ((LINE_W * FRAME_H * PIX_W) % DDR_W != 0) begin : g_bad_geometry
        $error("ddr2image: band size is not a whole number of DDR words");
    end
    if ((DDR_W < 2 * PIX_W) || (DDR_W % 8 != 0)) begin : g_bad_ddr_w
        $error("ddr2image: DDR_W must be >= 2*PIX_W and a multiple of 8");
    end

    localparam logic [WCNT_W-1:0]     WORDS_F   = WCNT_W'(WORDS_PER_BAND);
    localparam logic [WCNT_W-1:0]     WORDS_M1  = WCNT_W'(WORDS_PER_BAND - 1);
    localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(LINE_W - 1);
    localparam logic [LINE_CNT_W-1:0] LINE_LAST = LINE_CNT_W'(FRAME_H - 1);

    state_t                  state_r;
    logic                    busy_r;
    logic                    done_r;
    logic [WCNT_W-1:0]       word_cnt_r;
    logic [COL_W-1:0]        col_r;
    logic [LINE_CNT_W-1:0]   line_r;
    logic                    accept_en_s;
    logic                    emit_en_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    col_last_s;
    logic                    band_last_s;
    logic                    start_ok_s;

    assign accept_en_s = (state_r == RUN) && (word_cnt_r < WORDS_F);
    assign emit_en_s   = (state_r == RUN) || (state_r == DRAIN);
    assign push_s      = in_valid && in_ready;
    assign pop_s       = out_valid && out_ready;
    assign start_ok_s  = (state_r == IDLE) && start;
    assign col_last_s  = (col_r == COL_LAST);
    assign band_last_s = col_last_s && (line_r == LINE_LAST);

    assign busy    = busy_r;
    assign done    = done_r;
    assign out_sof = out_valid && (col_r == '0) && (line_r == '0);
    assign out_sol = out_valid && (col_r == '0);
    assign out_eol = out_valid && col_last_s;

    pix_gearbox u_gearbox (
        .clk       (clk_266),
        .rst       (rst_266),
        .accept_en (accept_en_s),
        .emit_en   (emit_en_s),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix)
    );

    // Band sequencer with registered busy/done
    always_ff @(posedge clk_266) begin
        if (rst_266) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                    end
                end
                RUN: begin
                    // Leave RUN on the push of the final word so no extra word slips in
                    if (push_s && (word_cnt_r == WORDS_M1)) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop_s && band_last_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Word counter (push side) and column/line counters (pop side)
    always_ff @(posedge clk_266) begin
        if (rst_266 || start_ok_s) begin
            word_cnt_r <= '0;
            col_r      <= '0;
            line_r     <= '0;
        end else begin
            if (push_s) begin
                word_cnt_r <= word_cnt_r + WCNT_W'(1);
            end
            if (pop_s) begin
                if (col_last_s) begin
                    col_r  <= '0;
                    line_r <= (line_r == LINE_LAST) ? '0 : line_r + LINE_CNT_W'(1);
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
            end
        end
    end

`ifdef DDR2IMAGE_STALL_CNT_EN
    logic [31:0] stall_r;

    // Saturating count of RUN cycles where the consumer waits on an empty gearbox
    always_ff @(posedge clk_266) begin
        if (rst_266 || start_ok_s) begin
            stall_r <= 32'd0;
        end else if ((state_r == RUN) && out_ready && !out_valid && (stall_r != 32'hFFFF_FFFF)) begin
            stall_r <= stall_r + 32'd1;
        end
    end

    assign stall_cnt = stall_r;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ddr2image.sv
// tb_ddr2image: scoreboard bench for ddr2image. Expected pixels are queued when
// the DDR word that completes them is accepted and checked when popped.
module tb_ddr2image;

    localparam int LW     = 1280;
    localparam int FH     = 16;
    localparam int PW     = 24;
    localparam int DW     = 512;
    localparam int NPIX   = LW * FH;
    localparam int NWORDS = NPIX * PW / DW;

    logic          clk_266 = 1'b0;
    logic          rst_266;
    logic          start;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_pix;
    logic          out_sof;
    logic          out_sol;
    logic          out_eol;
    logic [31:0]   stall_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [26:0] exp_q[$];
    int          pix_idx;
    int          words;
    int          next_p;
    int          done_cnt;
    bit          mon_en = 1'b0;
    bit          throttle = 1'b0;
    bit          band_end;
    bit          prev_stall = 1'b0;
    bit          prev_last_pop = 1'b0;
    logic [26:0] prev_out;

    ddr2image dut (
        .clk_266   (clk_266),
        .rst_266   (rst_266),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_sof   (out_sof),
        .out_sol   (out_sol),
        .out_eol   (out_eol),
        .stall_cnt (stall_cnt)
    );

    always #5 clk_266 = ~clk_266;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (pixel %0d)", tag, got, exp, pix_idx);
        end
    endtask

    // Word w holds stream bits [w*DW, w*DW+DW-1]; pixel p has value p+1, MSB first
    function automatic logic [DW-1:0] make_word(input int w);
        logic [DW-1:0] d;
        logic [PW-1:0] v;
        int            g;
        for (int i = 0; i < DW; i++) begin
            g = w * DW + i;
            v = PW'(g / PW + 1);
            d[DW-1-i] = v[PW-1-(g % PW)];
        end
        return d;
    endfunction

    function automatic logic [26:0] exp_rec(input int p);
        logic [PW-1:0] v;
        v = PW'(p + 1);
        return {(p == 0), (p % LW == 0), (p % LW == LW - 1), v};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_in_ready"}, in_ready, 1'b0);
        check_eq({tag, "_out_valid"}, out_valid, 1'b0);
        check_eq({tag, "_out_pix"}, out_pix, 24'h0);
        check_eq({tag, "_flags"}, {out_sof, out_sol, out_eol}, 3'b000);
        check_eq({tag, "_stall_cnt"}, stall_cnt, 32'd0);
    endtask

    // Output monitor: scoreboard pop, stall stability, done latency, fill bound
    always @(negedge clk_266) begin
        bit last_now;
        last_now = 1'b0;
        if (mon_en) begin
            if (prev_stall) begin
                check_eq("stall_hold", {out_valid, out_sof, out_sol, out_eol, out_pix}, {1'b1, prev_out});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_pix", 1'b1, 1'b0);
                end else begin
                    check_eq("pix", {out_sof, out_sol, out_eol, out_pix}, exp_q.pop_front());
                end
                if (pix_idx == 21) begin
                    check_eq("pix21_straddle", out_pix, 24'h000016);
                end
                last_now = (pix_idx == NPIX - 1);
                pix_idx++;
            end
            if (done) begin
                done_cnt++;
                check_eq("done_latency", prev_last_pop, 1'b1);
                check_eq("busy_at_done", busy, 1'b0);
            end
            if (throttle) begin
                check_eq("fill_bound", dut.u_gearbox.fill_r > 11'd1024, 1'b0);
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_sof, out_sol, out_eol, out_pix};
        end else begin
            prev_stall = 1'b0;
        end
        prev_last_pop = last_now;
    end

    task automatic run_band(input bit thr, input bit mid_start, input int abort_at);
        exp_q.delete();
        pix_idx       = 0;
        words         = 0;
        next_p        = 0;
        done_cnt      = 0;
        band_end      = 1'b0;
        throttle      = thr;
        prev_last_pop = 1'b0;
        out_ready     = 1'b1;
        in_valid      = 1'b0;
        mon_en        = 1'b1;
        @(posedge clk_266); #1;
        start = 1'b1;
        @(posedge clk_266); #1;
        start = 1'b0;
        check_eq("busy_after_start", busy, 1'b1);
        check_eq("in_ready_after_start", in_ready, 1'b1);
        in_data = make_word(0);
        fork
            begin : feeder
                while (words < NWORDS && !band_end) begin
                    in_valid = thr ? ($urandom_range(0, 99) >= 25) : 1'b1;
                    @(negedge clk_266);
                    if (in_valid && in_ready) begin
                        while (next_p < NPIX && (next_p * PW + PW - 1) / DW <= words) begin
                            exp_q.push_back(exp_rec(next_p));
                            next_p++;
                        end
                        words++;
                        if (mid_start && words == 100) start = 1'b1;
                    end
                    @(posedge clk_266); #1;
                    start = 1'b0;
                    if (words < NWORDS) in_data = make_word(words);
                end
                in_valid = 1'b0;
            end
            begin : readies
                while (!band_end) begin
                    @(posedge clk_266); #1;
                    out_ready = thr ? ($urandom_range(0, 99) >= 30) : 1'b1;
                end
            end
            begin : watcher
                int cyc;
                cyc = 0;
                while (!band_end) begin
                    @(negedge clk_266);
                    cyc++;
                    if (done) begin
                        band_end = 1'b1;
                    end else if (abort_at >= 0 && pix_idx >= abort_at) begin
                        band_end = 1'b1;
                        mon_en   = 1'b0;
                        @(posedge clk_266); #1;
                        rst_266 = 1'b1;
                        @(posedge clk_266); #1;
                        check_reset_outputs("rst_mid_band");
                        rst_266 = 1'b0;
                    end else if (cyc >= 60000) begin
                        check_eq("band_timeout", 1'b0, 1'b1);
                        band_end = 1'b1;
                    end
                end
            end
        join
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (abort_at < 0) begin
            repeat (5) @(negedge clk_266);
            check_eq("words_accepted", words, NWORDS);
            check_eq("pixels_emitted", pix_idx, NPIX);
            check_eq("queue_empty", exp_q.size(), 0);
            check_eq("done_pulses", done_cnt, 1);
            check_eq("in_ready_after_done", in_ready, 1'b0);
            check_eq("busy_after_done", busy, 1'b0);
        end
        mon_en   = 1'b0;
        throttle = 1'b0;
    endtask

    initial begin
        rst_266   = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        pix_idx   = 0;
        repeat (3) @(posedge clk_266);
        #1;
        check_reset_outputs("rst_init");
        rst_266 = 1'b0;

        // Starvation counter: 10 RUN cycles with no input and a ready consumer
        out_ready = 1'b1;
        @(posedge clk_266); #1;
        start = 1'b1;
        @(posedge clk_266); #1;
        start = 1'b0;
        repeat (10) @(posedge clk_266);
        #1;
`ifdef DDR2IMAGE_STALL_CNT_EN
        check_eq("stall_cnt_10", stall_cnt, 32'd10);
`else
        check_eq("stall_cnt_off", stall_cnt, 32'd0);
`endif
        rst_266 = 1'b1;
        @(posedge clk_266); #1;
        check_reset_outputs("rst_after_stall");
        rst_266 = 1'b0;

        run_band(1'b0, 1'b0, -1);    // full band, no throttling
        run_band(1'b1, 1'b1, -1);    // backpressure, input gaps, ignored mid-RUN start
        run_band(1'b0, 1'b0, 5000);  // reset mid-band
        run_band(1'b1, 1'b0, 100);   // fresh start restarts at pixel 0

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ddr2image.md
# ddr2image

Read-side counterpart of the camera-to-DDR packer: accepts 512-bit words returned by the DDR read path, unpacks them into a 24-bit RGB pixel stream, and tags line and frame boundaries for one band of LINE_W × FRAME_H pixels per `start`. It sits between the DDR read-data FIFO and the display/processing pipeline. Packing is the inverse of the write side: pixels are MSB-first and contiguous, and may straddle word boundaries; 3 words carry exactly 64 pixels.

## Interface
- LINE_W, 1280, pixels per line
- FRAME_H, 16, lines per band
- DDR_W, 512, DDR data word width; must be ≥ 2·PIX_W and a multiple of 8
- PIX_W, 24, pixel width (RGB888)
- clk_266  in  1  block clock. One clock only.
- rst_266  in  1  reset. Synchronous, active-high.
- start  in  1  pulse; begins one band; ignored unless idle
- busy  out  1  high from the cycle after an accepted `start` until `done`
- done  out  1  one-cycle pulse when the last pixel of the band is consumed
- in_valid  in  1  DDR word valid
- in_ready  out  1  word accepted when in_valid && in_ready
- in_data  in  DDR_W  DDR word; bit DDR_W-1 is the MSB of the earliest pixel
- out_valid  out  1  pixel valid
- out_ready  in  1  pixel consumed when out_valid && out_ready
- out_pix  out  PIX_W  pixel {R,G,B}
- out_sof  out  1  qualifies out_pix as pixel 0 of the band
- out_sol  out  1  qualifies out_pix as first pixel of a line
- out_eol  out  1  qualifies out_pix as last pixel of a line
- stall_cnt  out  32  starvation counter (see Configuration)

## Operation
- WORDS = LINE_W·FRAME_H·PIX_W/DDR_W. The default is 960. The product must be divisible by DDR_W; an elaboration-time check enforces this.
- FSM states:
  - IDLE: in_ready=0. On `start`, go to RUN.
  - RUN: accept words until WORDS have been taken, then go to DRAIN.
  - DRAIN: in_ready=0. Emit the remaining pixels. On the last pixel pop, assert `done` and go to IDLE.
- Gearbox: residue register of 2·DDR_W bits, MSB-aligned, with fill counter `fill` (bits valid from the top).
  - out_pix = residue top PIX_W bits.
  - out_valid = (fill ≥ PIX_W) in RUN or DRAIN.
  - in_ready = (fill ≤ DDR_W) in RUN, evaluated on the registered fill.
- Pop: shift left by PIX_W and reduce fill by PIX_W.
- Push: place the word immediately below the post-pop valid bits and add DDR_W to fill.
- Simultaneous push and pop in one cycle are both performed.
- Counters:
  - Pixel column counter 0..LINE_W-1 and line counter 0..FRAME_H-1, both advancing on pop.
  - out_sol = (col==0); out_eol = (col==LINE_W-1); out_sof = (col==0 && line==0).
  - Both counters wrap to 0 at band end.
- Word counter 0..WORDS advances on push. Words beyond WORDS are never accepted.
- `start` during RUN or DRAIN is ignored. The next band requires a new `start` after `done`.
- Reset (any time, including mid-band): state IDLE, fill 0, residue 0, all counters 0.
- Reset values of all outputs: busy 0, done 0, in_ready 0, out_valid 0, out_pix 0, out_sof/sol/eol 0, stall_cnt 0.

## Timing
- `start` in cycle N: state is RUN in cycle N+1, and in_ready is 1 in cycle N+1.
- First word accepted in cycle M: out_valid is 1 in cycle M+1 with pixel 0 and out_sof=1.
- Sustained throughput: 1 pixel/cycle with out_ready held high and the input never starved. Input demand is 24/512 word per cycle.
- out_* are register outputs and hold stable while out_valid && !out_ready.
- Last pop in cycle K: done=1 in cycle K+1, busy=0 in cycle K+1, state is IDLE in cycle K+1.
- Default geometry: exactly 20480 pops per band, with no residue left at `done`.

## Configuration
- DDR2IMAGE_STALL_CNT_EN defined:
  - stall_cnt increments each cycle in RUN with out_ready=1 and out_valid=0.
  - Saturates at 2^32-1.
  - Clears on reset and on an accepted `start`.
- DDR2IMAGE_STALL_CNT_EN undefined: stall_cnt is tied to 0 and no counter logic is built.

## Structure
- Shared package `image_pkg`:
  - Constants LINE_W, FRAME_H, PIX_W, DDR_W.
  - Derived WORDS_PER_BAND.
  - FSM state enum (IDLE, RUN, DRAIN).
- One sub-module, `pix_gearbox`: residue register, fill counter, push/pop logic, in_ready/out_valid generation.
- Top `ddr2image` holds the FSM, the word/column/line counters, and the stall counter.

## Test plan
- Reset, then `start`; feed word 0 = 0x000001_000002_…, consecutive 24-bit values MSB-first, with out_ready=1. Expect:
  - out_pix = 0x000001, 0x000002, … in order.
  - The pixel at index 21 is assembled from the low 8 bits of word 0 and the top 16 bits of word 1.
- Full band, default parameters. Expect:
  - Exactly 960 words accepted and 20480 pixels emitted.
  - out_sol every 1280 pixels, out_eol on pixel 1279 of each line, out_sof only on pixel 0.
  - `done` pulses once; in_ready stays 0 afterwards.
- Random out_ready backpressure at 30% and random in_valid gaps. Expect:
  - Pixel sequence identical to the unthrottled run.
  - out_pix stable while stalled.
  - fill never exceeds 2·DDR_W.
- `start` pulsed again mid-RUN: ignored, and the word count still ends at 960. rst_266 asserted at pixel 5000: all outputs return to reset values the next cycle, and a fresh `start` restarts at pixel 0 with out_sof=1.
- DDR2IMAGE_STALL_CNT_EN defined: hold in_valid=0 for 10 cycles after `start` with out_ready=1, expect stall_cnt=10. Without the macro, stall_cnt=0.
